// File: rtl/product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : product_accumulator                                           |
// | Purpose  : Accumulates up to LEN unsigned products per frame and         |
// |            presents the frame sum and product count on a valid/ready     |
// |            output. Input and output both use valid/ready handshakes.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int LEN    = 4,
  parameter int CNT_W  = $clog2(LEN + 1),
  parameter int ACC_W  = PROD_W + $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_n
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(LEN - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ACC_W-1:0]   sum_q,   sum_d;
  logic [CNT_W-1:0]   n_q,     n_d;
  logic               valid_q, valid_d;

  logic               w_accept;
  logic               w_final;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_cnt_next;

  // Ready is a function of state and clear only, so it never depends on out_ready.
  assign in_ready   = (state_q == ST_ACCUM) && !clear;
  assign w_accept   = in_valid && in_ready;
  assign w_final    = (cnt_q == c_LAST_IDX) || in_last;
  assign w_acc_next = acc_q + {{(ACC_W - PROD_W){1'b0}}, in_prod};
  assign w_cnt_next = cnt_q + CNT_W'(1);

  assign out_valid  = valid_q;
  assign out_sum    = sum_q;
  assign out_n      = n_q;

  // Next-state logic: clear overrides everything except reset.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    n_d     = n_q;
    valid_d = valid_q;

    if (clear) begin
      if (state_q == ST_ACCUM) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        valid_d = 1'b0;
        state_d = ST_ACCUM;
      end
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_final) begin
              sum_d   = w_acc_next;
              n_d     = w_cnt_next;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              acc_d = w_acc_next;
              cnt_d = w_cnt_next;
            end
          end
        end
        ST_HOLD: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      n_q     <= n_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_product_accumulator                                        |
// | Purpose  : Directed self-checking bench for product_accumulator.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_product_accumulator;

  localparam int PROD_W = 8;
  localparam int LEN    = 4;
  localparam int CNT_W  = $clog2(LEN + 1);
  localparam int ACC_W  = PROD_W + $clog2(LEN);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_n;

  int n_checks = 0;
  int n_fail   = 0;

  product_accumulator #(
    .PROD_W(PROD_W),
    .LEN   (LEN),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_n    (out_n)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product for exactly one cycle (in_ready is expected high).
  task automatic send(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = '0;
  endtask

  task automatic check_result(input string tag, input int sum, input int n);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(sum));
    check({tag, "_n"},     32'(out_n),     32'(n));
    check({tag, "_rdy0"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'd0);
    check("rst_n",     32'(out_n),     32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Full frame, back-to-back.
    send(8'd15, 1'b0);
    send(8'd4,  1'b0);
    send(8'd12, 1'b0);
    send(8'd14, 1'b0);
    check_result("full", 45, 4);
    step();
    check("full_done_valid", 32'(out_valid), 32'd0);
    check("full_done_rdy",   32'(in_ready),  32'd1);

    // Short frame terminated by in_last.
    send(8'd36, 1'b0);
    send(8'd4,  1'b1);
    check_result("short", 40, 2);
    step();
    check("short_done_valid", 32'(out_valid), 32'd0);

    // Backpressure with maximum products; in_valid during HOLD is ignored.
    out_ready = 1'b0;
    send(8'd225, 1'b0);
    send(8'd225, 1'b0);
    send(8'd225, 1'b0);
    send(8'd225, 1'b0);
    check_result("bp", 900, 4);
    in_valid = 1'b1;
    in_prod  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(out_sum),   32'd900);
      check("bp_hold_n",     32'(out_n),     32'd4);
      check("bp_hold_rdy",   32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    step();
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_rdy",   32'(in_ready),  32'd1);
    // Single-product frame proves the held-off products were not absorbed.
    send(8'd1, 1'b1);
    check_result("one", 1, 1);
    step();

    // Gapped input: idle cycles do not count.
    send(8'd2, 1'b0);
    step();
    send(8'd3, 1'b0);
    step();
    send(8'd4, 1'b0);
    step();
    send(8'd5, 1'b0);
    check_result("gap", 14, 4);
    step();

    // in_last coinciding with the LEN-th product is a normal full frame.
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    check_result("lastfull", 10, 4);
    step();

    // clear mid-frame discards the partial sum and blocks that cycle's input.
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd99;
    #1;
    check("clr_rdy", 32'(in_ready), 32'd0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_prod  = '0;
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    check_result("clr", 4, 4);
    step();

    // clear in HOLD drops the result without a handshake.
    out_ready = 1'b0;
    send(8'd50, 1'b1);
    check_result("clrhold", 50, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    check("clrhold_valid", 32'(out_valid), 32'd0);
    check("clrhold_rdy",   32'(in_ready),  32'd1);

    // rst mid-frame.
    out_ready = 1'b1;
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    rst = 1'b1;
    step();
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_sum",   32'(out_sum),   32'd0);
    check("rstmid_n",     32'(out_n),     32'd0);
    rst = 1'b0;
    #1;
    check("rstmid_rdy", 32'(in_ready), 32'd1);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    check_result("rstmid_frame", 32, 4);
    step();

    // rst in HOLD.
    out_ready = 1'b0;
    send(8'd3, 1'b1);
    check_result("rsthold_pre", 3, 1);
    rst = 1'b1;
    step();
    check("rsthold_valid", 32'(out_valid), 32'd0);
    check("rsthold_sum",   32'(out_sum),   32'd0);
    check("rsthold_n",     32'(out_n),     32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rsthold_rdy", 32'(in_ready), 32'd1);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    send(8'd8, 1'b0);
    check_result("rsthold_frame", 32, 4);
    step();
    check("final_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
